freq_meter: RTL and testbench

Frequency meter for the divider outputs. It counts rising edges of an asynchronous input over a fixed gate window of reference-clock cycles, then reports the count once per window. With a 60 MHz reference and the default 1 s gate, the reported count is the input frequency in Hz. It sits on the receiving end of a divided clock, either for on-chip self-check of the divider output or for measuring an external signal on a spare input pin.

---
 rtl/freq_meter_pkg.sv | 26 ++
 rtl/freq_meter_sync.sv | 43 ++++
 rtl/freq_meter.sv | 144 ++++++++++++++
 tb/tb_freq_meter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared types and constants for the frequency meter.
//   state_t    : measurement FSM states (IDLE, GATE)
//   DEF_CNT_W  : default edge/gate counter width
//   CLK_HZ     : nominal reference clock frequency
//   GATE_1S    : gate length giving a count in Hz at CLK_HZ
//   GATE_10MS  : short gate (count in units of 100 Hz)
// -----------------------------------------------------------------------------
package freq_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  localparam int DEF_CNT_W = 26;
  localparam int CLK_HZ    = 60000000;
  localparam int GATE_1S   = 60000000;
  localparam int GATE_10MS = 600000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/freq_meter_sync.sv
// -----------------------------------------------------------------------------
// freq_meter_sync
// Brings the asynchronous measured signal into the clock domain and detects
// its rising edges.
//   clock  : reference clock
//   reset  : asynchronous, active-low
//   sig_in : measured signal, asynchronous to clock
//   prime  : high while the meter is idle; suppresses rise
//   rise   : one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module freq_meter_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  input  logic prime,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // NOTE: every flop here, history included, is reset so a released block
  // never sees a stale level that could fake an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the chain shift one stage per
      // clock regardless of statement order.
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // History tracks the synchronized level every cycle, so on the first GATE
  // cycle it already holds the idle level; an input that was high before the
  // window opened therefore produces no edge. While priming, rise is masked.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q & ~prime;

endmodule

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Counts rising edges of sig_in over a window of GATE_CYCLES reference clocks
// and reports the count once per window; windows run back to back while en=1.
//   clock        : reference clock
//   reset        : asynchronous, active-low
//   en           : measurement enable
//   sig_in       : measured signal (asynchronous)
//   freq_out     : edge count of the last completed window
//   freq_valid   : one-cycle pulse when freq_out updates
//   freq_ovf     : last completed window saturated the edge counter
//   busy         : window in progress
//   period_out   : clocks between the last two rising edges
//   period_valid : one-cycle pulse when period_out updates
// Build option: FREQ_METER_PERIOD_EN enables the period counter; otherwise
// period_out/period_valid are tied to 0.
// -----------------------------------------------------------------------------
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_CYCLES = GATE_1S,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             freq_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid
);

  // The gate counter is never narrower than CNT_W, but widens when a small
  // edge counter is paired with a long window.
  localparam int                GATE_W    = max_int(CNT_W, $clog2(GATE_CYCLES));
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state_q, state_d;
  logic [GATE_W-1:0] gate_q;
  logic [CNT_W-1:0]  edge_q, edge_next;
  logic              ovf_q, ovf_next;
  logic              rise, last, in_gate;

  freq_meter_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .reset  (reset),
    .sig_in (sig_in),
    .prime  (state_q == IDLE),
    .rise   (rise)
  );

  assign in_gate = (state_q == GATE);
  assign last    = in_gate && (gate_q == GATE_LAST);
  assign busy    = in_gate;

  // Edge count and flag including this cycle's rise; used both for the
  // running count and for the end-of-window report.
  always_comb begin
    edge_next = edge_q;
    ovf_next  = ovf_q;
    if (rise) begin
      if (edge_q == CNT_MAX) ovf_next  = 1'b1;
      else                   edge_next = edge_q + CNT_W'(1);
    end
  end

  // NOTE: next state gets its default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = GATE;
      GATE:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      freq_out   <= '0;
      freq_ovf   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_valid <= last;
      if (last) begin
        freq_out <= edge_next;
        freq_ovf <= ovf_next;
      end
      // Restart on window end, on disable (window discarded) and in IDLE.
      if (!in_gate || last || !en) begin
        gate_q <= '0;
        edge_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        gate_q <= gate_q + GATE_W'(1);
        edge_q <= edge_next;
        ovf_q  <= ovf_next;
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_q;
  logic             seen_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      per_cnt_q    <= '0;
      seen_q       <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
    end else if (!in_gate) begin
      per_cnt_q    <= '0;
      seen_q       <= 1'b0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= rise & seen_q;
      if (rise) begin
        per_cnt_q <= '0;
        seen_q    <= 1'b1;
        // The counter holds distance-1 on the rise cycle itself.
        if (seen_q)
          period_out <= (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_W'(1);
      end else if (per_cnt_q != CNT_MAX) begin
        per_cnt_q <= per_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign period_out   = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
// Self-checking bench for freq_meter with GATE_CYCLES=100. A second instance
// with CNT_W=4 sees the same stimulus to exercise edge-counter saturation.
// -----------------------------------------------------------------------------
module tb_freq_meter;

  localparam int GC = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        sig_in = 1'b0;
  logic [25:0] freq_out, period_out;
  logic        freq_valid, freq_ovf, busy, period_valid;
  logic [3:0]  f4_out, p4_out;
  logic        f4_valid, f4_ovf, f4_busy, p4_valid;

  freq_meter #(.CNT_W(26), .GATE_CYCLES(GC), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .en(en), .sig_in(sig_in),
    .freq_out(freq_out), .freq_valid(freq_valid), .freq_ovf(freq_ovf),
    .busy(busy), .period_out(period_out), .period_valid(period_valid)
  );

  freq_meter #(.CNT_W(4), .GATE_CYCLES(GC), .SYNC_STAGES(2)) dut4 (
    .clock(clock), .reset(reset), .en(en), .sig_in(sig_in),
    .freq_out(f4_out), .freq_valid(f4_valid), .freq_ovf(f4_ovf),
    .busy(f4_busy), .period_out(p4_out), .period_valid(p4_valid)
  );

  always #5 clock = ~clock;

  // Stimulus generator: mode 0 = low, 1 = high, N>=2 = period N clocks
  // (N/2 high), changing on the falling edge.
  int mode = 0;
  int ph   = 0;
  always @(negedge clock) begin
    if (mode == 0)      sig_in = 1'b0;
    else if (mode == 1) sig_in = 1'b1;
    else begin
      sig_in = (ph < mode / 2);
      ph     = (ph + 1 >= mode) ? 0 : ph + 1;
    end
  end

  // Period monitor.
  int exp_per = 0;
  int pv_cnt  = 0;
  int pv_bad  = 0;
  int po_nz   = 0;
  always @(negedge clock) begin
    if (period_valid) begin
      pv_cnt++;
      if (period_out != 26'(exp_per)) pv_bad++;
    end
    if (period_out != '0) po_nz++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act,
                           input longint exp, input longint tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Counts falling edges until freq_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!freq_valid && n < 400);
  endtask

  task automatic do_reset();
    en    = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    exp_f;
    int    tol;
    bit    exp_ovf;
    int    exp_f4;
    int    tol4;
    bit    exp_ovf4;
    int    exp_per;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    logic [25:0] saved;
    int vcnt;

    vecs[0] = '{"p10",    10, 10, 1, 1'b0, 10, 1, 1'b0, 10};
    vecs[1] = '{"high",    1,  0, 0, 1'b0,  0, 0, 1'b0,  0};
    vecs[2] = '{"low",     0,  0, 0, 1'b0,  0, 0, 1'b0,  0};
    vecs[3] = '{"toggle",  2, 50, 1, 1'b0, 15, 0, 1'b1,  2};

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_freq_out", freq_out, 0);
    check("rst_flags", {freq_valid, freq_ovf, busy, period_valid}, 0);
    check("rst_period_out", period_out, 0);
    reset = 1'b1;
    @(negedge clock);

    // Table-driven windows.
    foreach (vecs[i]) begin
      do_reset();
      mode = vecs[i].mode;
      ph   = 0;
      repeat (10) @(negedge clock);
      exp_per = vecs[i].exp_per;
      pv_cnt  = 0;
      pv_bad  = 0;
      po_nz   = 0;
      en = 1'b1;
      wait_valid(n);
      check({vecs[i].name, "_first_lat"}, n, GC + 1);
      check_rng({vecs[i].name, "_w1_freq"}, freq_out, vecs[i].exp_f, vecs[i].tol);
      check({vecs[i].name, "_w1_ovf"}, freq_ovf, vecs[i].exp_ovf);
      check_rng({vecs[i].name, "_w1_f4"}, f4_out, vecs[i].exp_f4, vecs[i].tol4);
      check({vecs[i].name, "_w1_ovf4"}, f4_ovf, vecs[i].exp_ovf4);
      @(negedge clock);
      check({vecs[i].name, "_valid_pulse"}, freq_valid, 0);
      wait_valid(n);
      check({vecs[i].name, "_spacing"}, n + 1, GC);
      check_rng({vecs[i].name, "_w2_freq"}, freq_out, vecs[i].exp_f, vecs[i].tol);
      check({vecs[i].name, "_w2_ovf"}, freq_ovf, vecs[i].exp_ovf);
      check({vecs[i].name, "_w2_ovf4"}, f4_ovf, vecs[i].exp_ovf4);
`ifdef FREQ_METER_PERIOD_EN
      check({vecs[i].name, "_period_seen"}, pv_cnt > 0, vecs[i].exp_per != 0);
      check({vecs[i].name, "_period_bad"}, pv_bad, 0);
`else
      check({vecs[i].name, "_period_valid_off"}, pv_cnt, 0);
      check({vecs[i].name, "_period_out_off"}, po_nz, 0);
`endif
      en = 1'b0;
      @(negedge clock);
    end

    // Disable mid-window: discarded, held, re-enable latency.
    do_reset();
    mode = 10;
    ph   = 0;
    en   = 1'b1;
    wait_valid(n);
    saved = freq_out;
    check_rng("dis_pre_freq", saved, 10, 1);
    repeat (49) @(negedge clock);
    en = 1'b0;
    @(negedge clock);
    check("dis_busy", busy, 0);
    vcnt = 0;
    repeat (150) begin
      @(negedge clock);
      if (freq_valid) vcnt++;
    end
    check("dis_no_valid", vcnt, 0);
    check("dis_hold_freq", freq_out, saved);
    en = 1'b1;
    wait_valid(n);
    check("dis_reen_lat", n, GC + 1);

    // Reset mid-window: immediate clear, fresh first-report latency.
    do_reset();
    en = 1'b1;
    wait_valid(n);
    check_rng("rstmid_pre_freq", freq_out, 10, 1);
    repeat (40) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rstmid_outs", {freq_out, freq_ovf, freq_valid, busy}, 0);
    check("rstmid_period", {period_out, period_valid}, 0);
    @(negedge clock);
    reset = 1'b1;
    wait_valid(n);
    check("rstmid_lat", n, GC + 1);

    // en dropped on the last window cycle: still reported, then idle.
    do_reset();
    en = 1'b1;
    repeat (GC) @(negedge clock);
    en = 1'b0;
    @(negedge clock);
    check("last_valid", freq_valid, 1);
    check("last_busy", busy, 0);
    check_rng("last_freq", freq_out, 10, 1);
    @(negedge clock);
    check("last_valid_end", freq_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
